// File: rtl/nco_pkg.sv
// NCO front-end shared definitions: register offsets, CTRL/STATUS bit
// positions, default widths and a byte-lane write-merge helper.
package nco_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_OUT_W   = 12;
    localparam int DEF_DIV_W   = 16;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_FREQ   = 8'h04;
    localparam logic [7:0] OFF_POFF   = 8'h08;
    localparam logic [7:0] OFF_DIV    = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_PHASE  = 8'h14;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IRQ = 2;
    localparam int ST_OVR   = 0;
    localparam int ST_PEND  = 1;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? dat[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/nco_tick_div.sv
// Sample-rate divider: with enable high, counts 0..div and pulses tick on
// the terminal count. Ports: clk, rst (sync, active-high), enable, clear,
// div (terminal count), tick.
module nco_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so lowering div below the running count
    // terminates the current period instead of wrapping the counter.
    assign tick = enable & (cnt >= div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/nco_phase_wb.sv
// Wishbone register front end and phase accumulator of the NCO.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); wbs_* Wishbone slave;
// phase_o/phase_valid_o/phase_ready_i stream to the sine stage; irq_o.
module nco_phase_wb
    import nco_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          PHASE_W   = DEF_PHASE_W,
    parameter int          OUT_W     = DEF_OUT_W,
    parameter int          DIV_W     = DEF_DIV_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [OUT_W-1:0] phase_o,
    output logic             phase_valid_o,
    input  logic             phase_ready_i,
    output logic             irq_o
);

    logic               enable;
    logic               irq_en;
    logic               overrun;
    logic [PHASE_W-1:0] freq_shadow;
    logic [PHASE_W-1:0] freq_act;
    logic [PHASE_W-1:0] poff;
    logic [PHASE_W-1:0] acc;
    logic [DIV_W-1:0]   div_q;
    logic [OUT_W-1:0]   sum_top;
    logic [31:0]        rdata;
    logic [7:0]         off;
    logic               req;
    logic               wr;
    logic               wr_ctrl;
    logic               wr_freq;
    logic               wr_poff;
    logic               wr_div;
    logic               wr_stat;
    logic               clr;
    logic               w1c;
    logic               tick;
    logic               tick_eff;
    logic               ovr_set;

    assign off = wbs_adr_i[7:0];
    assign req = wbs_cyc_i & wbs_stb_i
               & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

    // Master holds the request through the ack cycle; commit there.
    assign wr      = wbs_ack_o & req & wbs_we_i;
    assign wr_ctrl = wr & (off == OFF_CTRL);
    assign wr_freq = wr & (off == OFF_FREQ);
    assign wr_poff = wr & (off == OFF_POFF);
    assign wr_div  = wr & (off == OFF_DIV);
    assign wr_stat = wr & (off == OFF_STATUS);

    assign clr = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
    assign w1c = wr_stat & wbs_sel_i[0] & wbs_dat_i[ST_OVR];

    assign tick_eff = tick & ~clr;
    assign ovr_set  = tick_eff & phase_valid_o & ~phase_ready_i;
    assign irq_o    = overrun & irq_en;

    assign sum_top = OUT_W'((acc + poff) >> (PHASE_W - OUT_W));

    nco_tick_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .enable (enable),
        .clear  (clr),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_EN]  = enable;
                rdata[CTRL_IRQ] = irq_en;
            end
            OFF_FREQ:  rdata = 32'(freq_shadow);
            OFF_POFF:  rdata = 32'(poff);
            OFF_DIV:   rdata = 32'(div_q);
            OFF_STATUS: begin
                rdata[ST_OVR]  = overrun;
                rdata[ST_PEND] = phase_valid_o;
            end
            OFF_PHASE: rdata = 32'(acc);
            default:   rdata = '0;
        endcase
    end

    // Ack every other cycle at most, so a held strobe is never re-acked
    // on the cycle right after an ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req & ~wbs_ack_o;
            wbs_dat_o <= (req & ~wbs_ack_o) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            freq_shadow <= '0;
            poff        <= '0;
            div_q       <= '0;
            overrun     <= 1'b0;
        end else begin
            if (wr_ctrl && wbs_sel_i[0]) begin
                enable <= wbs_dat_i[CTRL_EN];
                irq_en <= wbs_dat_i[CTRL_IRQ];
            end
            if (wr_freq) begin
                freq_shadow <= PHASE_W'(byte_merge(
                    32'(freq_shadow), wbs_dat_i, wbs_sel_i));
            end
            if (wr_poff) begin
                poff <= PHASE_W'(byte_merge(
                    32'(poff), wbs_dat_i, wbs_sel_i));
            end
            if (wr_div) begin
                div_q <= DIV_W'(byte_merge(
                    32'(div_q), wbs_dat_i, wbs_sel_i));
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (w1c) begin
                overrun <= 1'b0;
            end
        end
    end

    // The emitted phase is the pre-increment accumulator plus offset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            acc           <= '0;
            freq_act      <= '0;
            phase_o       <= '0;
            phase_valid_o <= 1'b0;
        end else begin
            if (!enable || tick_eff) begin
                freq_act <= freq_shadow;
            end
            if (clr) begin
                acc           <= '0;
                phase_valid_o <= 1'b0;
            end else if (tick_eff) begin
                acc <= acc + freq_act;
                if (!phase_valid_o || phase_ready_i) begin
                    phase_o       <= sum_top;
                    phase_valid_o <= 1'b1;
                end
            end else if (phase_valid_o && phase_ready_i) begin
                phase_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_wb.sv
// Directed bench for nco_phase_wb: register access, ack timing, phase
// stream, divider, overrun/W1C, clear and mid-run reset.
module tb_nco_phase_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [11:0] phase;
    logic        pvalid;
    logic        ready = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nco_phase_wb dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .phase_o       (phase),
        .phase_valid_o (pvalid),
        .phase_ready_i (ready),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd);
        bit got;
        got = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = a; wdat = d; sel = s;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (ack) got = 1;
        end
        check("wb_ack", 32'(got), 32'd1);
        rd = rdat;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] o, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] rd;
        wb_cycle(BASE + 32'(o), 1'b1, d, s, rd);
    endtask

    task automatic check_rd(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
        logic [31:0] rd;
        wb_cycle(a, 1'b0, '0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    task automatic wait_sample(output logic [11:0] p);
        bit got;
        got = 0;
        p = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (pvalid) begin
                got = 1;
                p = phase;
            end
        end
        check("sample_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] p1, p2, p3, d1, d2;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_valid", 32'(pvalid), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_rd("rst_reg", BASE + 32'(4 * i), 32'h0);
        end

        // held strobe: ack, gap, ack again
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
        @(negedge clk);
        check("ack_first", 32'(ack), 32'h1);
        @(negedge clk);
        check("ack_gap", 32'(ack), 32'h0);
        @(negedge clk);
        check("ack_again", 32'(ack), 32'h1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        wb_write(8'h04, 32'hFFFF_FFFF, 4'b0001);
        check_rd("freq_sel", BASE + 32'h04, 32'h0000_00FF);
        check_rd("unmapped", BASE + 32'h40, 32'h0);

        seen = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
        repeat (4) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        cyc = 1'b0; stb = 1'b0;
        check("off_page_ack", 32'(seen), 32'h0);

        // free-running stream, DIV=0
        ready = 1'b1;
        wb_write(8'h04, 32'h1000_0000, 4'hF);
        wb_write(8'h08, 32'h0, 4'hF);
        wb_write(8'h0C, 32'h0, 4'hF);
        check_rd("freq_rb", BASE + 32'h04, 32'h1000_0000);
        wb_write(8'h00, 32'h1, 4'hF);
        wait_sample(p1);
        check("stream_0", 32'(p1), 32'h000);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("stream_v", 32'(pvalid), 32'h1);
            check("stream_p", 32'(phase), 32'((i * 'h100) & 'hFFF));
        end

        // clear mid-stream
        wb_write(8'h08, 32'h0AB0_0000, 4'hF);
        wb_write(8'h00, 32'h3, 4'hF);
        @(negedge clk);
        check("clr_valid", 32'(pvalid), 32'h0);
        @(negedge clk);
        check("clr_v1", 32'(pvalid), 32'h1);
        check("clr_p1", 32'(phase), 32'h0AB);
        @(negedge clk);
        check("clr_p2", 32'(phase), 32'h1AB);
        check_rd("ctrl_rb", BASE, 32'h1);

        // DIV=3: one sample every 4 cycles
        wb_write(8'h0C, 32'h3, 4'hF);
        wb_write(8'h08, 32'h0, 4'hF);
        wb_write(8'h00, 32'h3, 4'hF);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("div_v", 32'(pvalid), 32'((k == 4 || k == 8) ? 1 : 0));
            if (k == 4) check("div_p4", 32'(phase), 32'h000);
            if (k == 8) check("div_p8", 32'(phase), 32'h100);
        end

        // FREQ change takes effect one tick late
        wb_write(8'h04, 32'h2000_0000, 4'hF);
        @(negedge clk);
        wait_sample(p1);
        wait_sample(p2);
        wait_sample(p3);
        d1 = p2 - p1;
        d2 = p3 - p2;
        check("step_old", 32'(d1), 32'h100);
        check("step_new", 32'(d2), 32'h200);

        // overrun with ready low
        wb_write(8'h00, 32'h2, 4'hF);
        ready = 1'b0;
        wb_write(8'h08, 32'h0AB0_0000, 4'hF);
        wb_write(8'h00, 32'h5, 4'hF);
        wait_sample(p1);
        check("ovr_first", 32'(p1), 32'h0AB);
        repeat (14) @(negedge clk);
        check("ovr_frozen", 32'(phase), 32'h0AB);
        check("ovr_valid", 32'(pvalid), 32'h1);
        check("ovr_irq", 32'(irq), 32'h1);
        check_rd("ovr_status", BASE + 32'h10, 32'h3);
        ready = 1'b1;
        wb_write(8'h00, 32'h4, 4'hF);
        repeat (2) @(negedge clk);
        wb_write(8'h10, 32'h1, 4'hF);
        @(negedge clk);
        check("w1c_irq", 32'(irq), 32'h0);
        check_rd("w1c_status", BASE + 32'h10, 32'h0);

        // reset mid-run
        wb_write(8'h00, 32'h1, 4'hF);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", 32'(pvalid), 32'h0);
        check("mrst_phase", 32'(phase), 32'h0);
        rst = 1'b0;
        check_rd("mrst_acc", BASE + 32'h14, 32'h0);
        check_rd("mrst_poff", BASE + 32'h08, 32'h0);
        check_rd("mrst_ctrl", BASE, 32'h0);
        wb_write(8'h08, 32'h0AB0_0000, 4'hF);
        wb_write(8'h00, 32'h1, 4'hF);
        wait_sample(p1);
        check("mrst_first", 32'(p1), 32'h0AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
